line_edit_buffer: RTL

- Downstream stage of the terminal command decoder.
- Holds one editable text line of up to LEN characters and applies the decoder's one-cycle strobes: left_cursor, right_cursor, Delete, Enter.
- Printable characters arrive from the receiver as char_valid/char_in.
- The line is readable by the display path through a random-access port. Enter streams it out over a valid/ready interface.

---
 rtl/line_edit_buffer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/line_edit_buffer.sv
// line_edit_buffer: one editable text line with cursor, insert and delete by
// shifting, random-access display read port and a valid/ready flush stream.
// Optional feature: define LINE_EDIT_BUFFER_DROP_CNT_EN to build the
// saturating dropped-event counter; otherwise drop_cnt is tied to zero.
module line_edit_buffer #(
    parameter int LEN = 32,
    parameter int AW  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    char_in,
    input  logic          char_valid,
    input  logic          left_cursor,
    input  logic          right_cursor,
    input  logic          Delete,
    input  logic          Enter,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   cursor_pos,
    output logic [AW:0]   line_len,
    output logic          busy,
    output logic          full,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic [7:0]    drop_cnt
);
    typedef enum logic [1:0] {IDLE, INS_SHIFT, DEL_SHIFT, FLUSH} state_t;

    localparam logic [AW:0] LEN_W    = (AW+1)'(LEN);
    localparam logic [AW:0] ONE_W    = (AW+1)'(1);
    localparam logic [7:0]  CH_SPACE = 8'h20;
    localparam logic [7:0]  CH_CR    = 8'h0D;

    state_t        state, state_next;
    logic [7:0]    mem [LEN];
    logic [AW:0]   idx;
    logic [7:0]    ins_char;

    logic          ev_char;
    logic          take_flush, take_delete, take_left, take_right, take_char;
    logic          del_last;
    logic [AW-1:0] idx_lo, idx_dn, idx_up, flush_next_lo;
    logic [AW:0]   flush_next;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    // Only printable, non-space characters count as typed input
    assign ev_char = char_valid && (char_in >= 8'h21) && (char_in <= 8'h7E);

    // Fixed priority among simultaneous strobes: Enter, Delete, left, right, char
    assign take_flush  = Enter;
    assign take_delete = !Enter && Delete;
    assign take_left   = !Enter && !Delete && left_cursor;
    assign take_right  = !Enter && !Delete && !left_cursor && right_cursor;
    assign take_char   = !Enter && !Delete && !left_cursor && !right_cursor && ev_char;

    assign full          = (line_len == LEN_W);
    assign busy          = (state != IDLE);
    assign idx_lo        = idx[AW-1:0];
    assign idx_dn        = idx_lo - AW'(1);
    assign idx_up        = idx_lo + AW'(1);
    // The last delete move is the one that fills slot line_len-2
    assign del_last      = ({1'b0, idx} + (AW+2)'(2)) >= {1'b0, line_len};
    assign flush_next    = idx + ONE_W;
    assign flush_next_lo = flush_next[AW-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and the single memory write port used by both shifts
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (take_flush)
                    state_next = FLUSH;
                else if (take_delete && (cursor_pos != line_len))
                    state_next = DEL_SHIFT;
                else if (take_right && (cursor_pos == line_len) && !full)
                    state_next = INS_SHIFT;
                else if (take_char && !full)
                    state_next = INS_SHIFT;
            end
            INS_SHIFT: begin
                mem_we    = 1'b1;
                mem_waddr = idx_lo;
                if (idx == cursor_pos) begin
                    mem_wdata  = ins_char;
                    state_next = IDLE;
                end else begin
                    mem_wdata = mem[idx_dn];
                end
            end
            DEL_SHIFT: begin
                mem_we    = 1'b1;
                mem_waddr = idx_lo;
                mem_wdata = mem[idx_up];
                if (del_last) state_next = IDLE;
            end
            FLUSH: begin
                if (out_valid && out_ready && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line storage; contents beyond line_len are don't-care so no reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Display read port, registered with one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

    // Cursor, length, shift index and flush stream registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_pos <= '0;
            line_len   <= '0;
            idx        <= '0;
            ins_char   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_flush) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        if (line_len == '0) begin
                            out_data <= CH_CR;
                            out_last <= 1'b1;
                        end else begin
                            out_data <= mem[0];
                            out_last <= 1'b0;
                        end
                    end else if (take_delete) begin
                        idx <= cursor_pos;
                    end else if (take_left) begin
                        if (cursor_pos != '0) cursor_pos <= cursor_pos - ONE_W;
                    end else if (take_right) begin
                        if (cursor_pos < line_len) begin
                            cursor_pos <= cursor_pos + ONE_W;
                        end else begin
                            idx      <= line_len;
                            ins_char <= CH_SPACE;
                        end
                    end else if (take_char) begin
                        idx      <= line_len;
                        ins_char <= char_in;
                    end
                end
                INS_SHIFT: begin
                    if (idx == cursor_pos) begin
                        cursor_pos <= cursor_pos + ONE_W;
                        line_len   <= line_len + ONE_W;
                    end else begin
                        idx <= idx - ONE_W;
                    end
                end
                DEL_SHIFT: begin
                    if (del_last) line_len <= line_len - ONE_W;
                    else          idx      <= idx + ONE_W;
                end
                FLUSH: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            line_len   <= '0;
                            cursor_pos <= '0;
                        end else begin
                            idx <= flush_next;
                            if (flush_next == line_len) begin
                                out_data <= CH_CR;
                                out_last <= 1'b1;
                            end else begin
                                out_data <= mem[flush_next_lo];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LINE_EDIT_BUFFER_DROP_CNT_EN
    logic [2:0] ev_count;
    logic [3:0] drop_inc;
    logic [8:0] drop_sum;
    logic [7:0] drop_q;

    assign ev_count = 3'(Enter) + 3'(Delete) + 3'(left_cursor) + 3'(right_cursor) + 3'(ev_char);
    assign drop_sum = {5'b0, drop_inc} + {1'b0, drop_q};
    assign drop_cnt = drop_q;

    // Drops this cycle: everything while busy, else all but the taken event plus taken no-ops
    always_comb begin
        drop_inc = {1'b0, ev_count};
        if (state == IDLE) begin
            if (ev_count != 3'd0)                                drop_inc = drop_inc - 4'd1;
            if (take_right && (cursor_pos == line_len) && full)  drop_inc = drop_inc + 4'd1;
            if (take_char && full)                               drop_inc = drop_inc + 4'd1;
        end
    end

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           drop_q <= '0;
        else if (drop_sum[8]) drop_q <= 8'hFF;
        else                  drop_q <= drop_sum[7:0];
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
